csf_byte_streamer: RTL and testbench

Downstream stage of the Canonical Serialization Format (CSF) state serializer. It captures the serializer's packed byte vector when `valid` is presented, then emits the bytes one per handshake on a valid/ready byte stream in wire order, byte 0 first. While streaming, it computes the CRC-32 (zlib/IEEE) of the emitted bytes. The stream feeds the UART/host link, and the CRC lets the host cross-check against Python `zlib.crc32` of the same CSF bytes.

---
 rtl/csf_byte_streamer.sv | 98 +++++++++
 tb/tb_csf_byte_streamer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/csf_byte_streamer.sv
// CSF byte streamer: captures a packed serializer frame and emits it byte 0 first
// on a valid/ready stream while accumulating the zlib CRC-32 of the emitted bytes.
module csf_byte_streamer #(
  parameter int MAX_BYTES = 46
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [8:0]             in_byte_count,
  input  logic [8*MAX_BYTES-1:0] in_data,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   crc_valid,
  output logic [31:0]            crc_out,
  output logic                   len_err
);

  localparam int         W    = 8 * MAX_BYTES;
  localparam logic [8:0] MAXC = 9'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t      state, state_nxt;
  logic [W-1:0] shreg;
  logic [8:0]  idx, len;
  logic [31:0] crc, crc_nxt;
  logic        armed;
  logic        take, count_ok, accept, is_last;

  // Reflected CRC-32 (0xEDB88320), eight bit-serial steps unrolled.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    take      = (state == IDLE) && in_valid && armed;
    count_ok  = (in_byte_count != 9'd0) && (in_byte_count <= MAXC);
    is_last   = (idx == len - 9'd1);
    accept    = (state == STREAM) && out_ready;
    crc_nxt   = crc_step(crc, shreg[7:0]);

    busy      = (state != IDLE);
    out_valid = (state == STREAM);
    out_data  = (state == STREAM) ? shreg[7:0] : 8'h00;
    out_last  = (state == STREAM) && is_last;
    crc_valid = (state == FINISH);
    len_err   = take && !count_ok;

    case (state)
      IDLE:    if (take && count_ok) state_nxt = STREAM;
      STREAM:  if (accept && is_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // crc_out is loaded on the last accept so it is already valid while crc_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= 9'd0;
      len     <= 9'd0;
      crc     <= 32'h00000000;
      crc_out <= 32'h00000000;
      armed   <= 1'b1;
    end else begin
      state <= state_nxt;

      if (!in_valid)
        armed <= 1'b1;
      else if (take)
        armed <= 1'b0;

      if (take && count_ok) begin
        shreg <= in_data;
        len   <= in_byte_count;
        idx   <= 9'd0;
        crc   <= 32'hFFFFFFFF;
      end else if (accept) begin
        crc   <= crc_nxt;
        shreg <= {8'h00, shreg[W-1:8]};
        idx   <= idx + 9'd1;
        if (is_last)
          crc_out <= crc_nxt ^ 32'hFFFFFFFF;
      end
    end
  end

endmodule

// File: tb/tb_csf_byte_streamer.sv
// Directed bench for csf_byte_streamer: known CSF frames, CRC check value,
// length rejection, level-held valid, backpressure and mid-frame reset.
module tb_csf_byte_streamer;

  localparam int MB = 46;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [8:0]    in_byte_count;
  logic [8*MB-1:0] in_data;
  logic          busy, out_valid, out_ready, out_last, crc_valid, len_err;
  logic [7:0]    out_data;
  logic [31:0]   crc_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] expBytes [0:MB-1];

  always #5 clk = ~clk;

  csf_byte_streamer #(.MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte_count(in_byte_count),
    .in_data(in_data), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .crc_valid(crc_valid),
    .crc_out(crc_out), .len_err(len_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
    total++;
    if (observed !== required) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, observed, required);
    end
  endtask

  // Reference CRC-32 fed one input bit at a time.
  function automatic logic [31:0] refCrc(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ expBytes[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic loadFrame46();
    for (int k = 0; k < MB; k++) expBytes[k] = 8'h00;
    expBytes[0]  = 8'h02;
    expBytes[12] = 8'h01;
    expBytes[16] = 8'h02;
    expBytes[20] = 8'h05;
    expBytes[24] = 8'h0A;
    expBytes[28] = 8'h01;
    expBytes[29] = 8'h2A;
  endtask

  task automatic loadAscii();
    for (int k = 0; k < MB; k++) expBytes[k] = 8'h00;
    for (int k = 0; k < 9; k++) expBytes[k] = 8'h31 + 8'(k);
  endtask

  // Presents a frame and lets the capture edge pass; in_valid stays high.
  task automatic applyStimulus(input logic [8:0] cnt);
    for (int k = 0; k < MB; k++) in_data[8*k +: 8] = expBytes[k];
    in_byte_count = cnt;
    in_valid      = 1'b1;
    #1;
    checkOutput("pre_busy", 32'(busy), 32'd0);
    checkOutput("pre_len_err", 32'(len_err), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic streamFrame(input int len, input bit randReady, input int stopAfter,
                             input logic [31:0] crcReq);
    int         got = 0;
    bit         stalled = 0;
    logic [7:0] heldData = 8'h00;
    logic       heldLast = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (stopAfter > 0 && got == stopAfter) return;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (got < len) begin
        checkOutput("stream_valid", 32'(out_valid), 32'd1);
        if (stalled) begin
          checkOutput("stall_data", 32'(out_data), 32'(heldData));
          checkOutput("stall_last", 32'(out_last), 32'(heldLast));
        end
        if (out_ready) begin
          checkOutput($sformatf("byte%0d", got), 32'(out_data), 32'(expBytes[got]));
          checkOutput($sformatf("last%0d", got), 32'(out_last), 32'(got == len - 1));
          got++;
          stalled = 0;
        end else begin
          stalled  = 1;
          heldData = out_data;
          heldLast = out_last;
        end
      end else begin
        checkOutput("crc_valid", 32'(crc_valid), 32'd1);
        checkOutput("finish_out_valid", 32'(out_valid), 32'd0);
        checkOutput("finish_busy", 32'(busy), 32'd1);
        checkOutput("crc_out", crc_out, crcReq);
        if (!randReady) checkOutput("crc_latency", 32'(cyc), 32'(len + 1));
        out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("crc_pulse_end", 32'(crc_valid), 32'd0);
        checkOutput("crc_hold", crc_out, crcReq);
        return;
      end
      @(posedge clk); #1;
    end
    checkOutput("stream_timeout", 32'(got), 32'(len + 1));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_byte_count = 9'd0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_crc_valid", 32'(crc_valid), 32'd0);
    checkOutput("rst_crc_out", crc_out, 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] 46-byte serializer frame, ready held");
    loadFrame46();
    applyStimulus(9'd46);
    in_valid = 1'b0;
    streamFrame(46, 1'b0, 0, refCrc(46));

    $display("[TB] CRC check string");
    loadAscii();
    applyStimulus(9'd9);
    in_valid = 1'b0;
    streamFrame(9, 1'b0, 0, 32'hCBF43926);

    $display("[TB] 46-byte frame with backpressure");
    loadFrame46();
    applyStimulus(9'd46);
    in_valid = 1'b0;
    streamFrame(46, 1'b1, 0, refCrc(46));

    $display("[TB] illegal lengths");
    in_byte_count = 9'd0; in_valid = 1'b1;
    #1;
    checkOutput("len0_err", 32'(len_err), 32'd1);
    @(posedge clk); #1;
    checkOutput("len0_err_pulse", 32'(len_err), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_byte_count = 9'd47; in_valid = 1'b1;
    #1;
    checkOutput("len47_err", 32'(len_err), 32'd1);
    @(posedge clk); #1;
    checkOutput("len47_err_pulse", 32'(len_err), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || busy) seen = 1;
      @(posedge clk); #1;
    end
    checkOutput("len_err_no_stream", 32'(seen), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] level-held valid");
    loadAscii();
    applyStimulus(9'd9);
    streamFrame(9, 1'b0, 0, 32'hCBF43926);
    seen = 0;
    for (int i = 0; i < 186; i++) begin
      if (out_valid || busy || len_err) seen = 1;
      @(posedge clk); #1;
    end
    checkOutput("held_single_frame", 32'(seen), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(9'd9);
    in_valid = 1'b0;
    streamFrame(9, 1'b0, 0, 32'hCBF43926);

    $display("[TB] reset mid-frame");
    loadFrame46();
    applyStimulus(9'd46);
    in_valid = 1'b0;
    streamFrame(46, 1'b0, 10, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_last", 32'(out_last), 32'd0);
    checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
    checkOutput("mid_rst_crc_valid", 32'(crc_valid), 32'd0);
    checkOutput("mid_rst_crc_out", crc_out, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (crc_valid || out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checkOutput("mid_rst_discard", 32'(seen), 32'd0);
    loadAscii();
    applyStimulus(9'd9);
    in_valid = 1'b0;
    streamFrame(9, 1'b0, 0, 32'hCBF43926);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
